// File: rtl/tick_watchdog.sv
// -----------------------------------------------------------------------------
// tick_watchdog
//   Consumer-side monitor for a periodic 1-cycle tick pulse train. Each period
//   between accepted ticks is checked against the window
//   [EXPECTED-TOLERANCE, EXPECTED+TOLERANCE]. Early ticks and missing ticks
//   count as misses. MISS_LIMIT consecutive misses declare loss of tick.
//
//   Optional build macro: TICK_WD_STATS_EN
//     Adds output good_count, a saturating count of good periods since
//     reset, clear or enable=0.
//
// Ports
//   clk          in   1      clock
//   reset        in   1      asynchronous reset, active-high
//   enable       in   1      1 = monitor; 0 = idle with all status cleared
//   tick_in      in   1      tick pulse, synchronous to clk
//   clear        in   1      1-cycle pulse: clears lost and miss_count
//   locked       out  1      last period was inside the window
//   early_err    out  1      1-cycle pulse: tick arrived before the window
//   late_err     out  1      1-cycle pulse: no tick by the end of the window
//   lost         out  1      sticky: MISS_LIMIT consecutive misses seen
//   miss_count   out  8      consecutive misses, saturating at 255
//   last_period  out  CNT_W  cycles between the last two accepted ticks
//   good_count   out  16     (TICK_WD_STATS_EN only) good periods, saturating
// -----------------------------------------------------------------------------
module tick_watchdog #(
    parameter int unsigned EXPECTED   = 250000000,
    parameter int unsigned TOLERANCE  = 1000,
    parameter int unsigned MISS_LIMIT = 3,
    parameter int unsigned CNT_W      = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             tick_in,
    input  logic             clear,
    output logic             locked,
    output logic             early_err,
    output logic             late_err,
    output logic             lost,
    output logic [7:0]       miss_count,
    output logic [CNT_W-1:0] last_period
`ifdef TICK_WD_STATS_EN
    ,
    output logic [15:0]      good_count
`endif
);

    localparam logic [CNT_W-1:0] LO_C  = CNT_W'(64'(EXPECTED) - 64'(TOLERANCE));
    localparam logic [CNT_W-1:0] HI_C  = CNT_W'(64'(EXPECTED) + 64'(TOLERANCE));
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [7:0]       MISS_LIM_C = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] interval_r;
    logic [7:0]       miss_inc_s;
    logic             miss_hit_s;

    // Saturating next miss count and whether a miss now would reach the limit
    always_comb begin
        if (miss_count == 8'hFF) begin
            miss_inc_s = 8'hFF;
        end else begin
            miss_inc_s = miss_count + 8'd1;
        end
        // A simultaneous clear cancels the miss's effect on lost/miss_count
        if ((miss_inc_s >= MISS_LIM_C) && !clear) begin
            miss_hit_s = 1'b1;
        end else begin
            miss_hit_s = 1'b0;
        end
    end

`ifdef TICK_WD_STATS_EN
    logic [15:0] good_inc_s;

    // Saturating next good-period count
    always_comb begin
        if (good_count == 16'hFFFF) begin
            good_inc_s = 16'hFFFF;
        end else begin
            good_inc_s = good_count + 16'd1;
        end
    end
`endif

    // Tracking FSM, interval counter and all registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            interval_r  <= ZERO_C;
            locked      <= 1'b0;
            early_err   <= 1'b0;
            late_err    <= 1'b0;
            lost        <= 1'b0;
            miss_count  <= 8'd0;
            last_period <= ZERO_C;
`ifdef TICK_WD_STATS_EN
            good_count  <= 16'd0;
`endif
        end else if (!enable) begin
            state_r     <= IDLE;
            interval_r  <= ZERO_C;
            locked      <= 1'b0;
            early_err   <= 1'b0;
            late_err    <= 1'b0;
            lost        <= 1'b0;
            miss_count  <= 8'd0;
            last_period <= ZERO_C;
`ifdef TICK_WD_STATS_EN
            good_count  <= 16'd0;
`endif
        end else begin
            early_err <= 1'b0;
            late_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    interval_r <= ZERO_C;
                    state_r    <= ACQUIRE;
                end
                ACQUIRE: begin
                    // First tick only arms the period measurement
                    if (tick_in) begin
                        interval_r <= ONE_C;
                        state_r    <= TRACK;
                    end else begin
                        interval_r <= ZERO_C;
                    end
                end
                TRACK: begin
                    if (tick_in) begin
                        // A tick at interval==HI is still good: tick wins over timeout
                        interval_r <= ONE_C;
                        if (interval_r < LO_C) begin
                            early_err  <= 1'b1;
                            locked     <= 1'b0;
                            miss_count <= miss_inc_s;
                            if (miss_hit_s) begin
                                lost    <= 1'b1;
                                state_r <= LOST;
                            end
                        end else begin
                            locked      <= 1'b1;
                            last_period <= interval_r;
                            miss_count  <= 8'd0;
`ifdef TICK_WD_STATS_EN
                            good_count  <= good_inc_s;
`endif
                        end
                    end else if (interval_r >= HI_C) begin
                        late_err   <= 1'b1;
                        locked     <= 1'b0;
                        interval_r <= ONE_C;
                        miss_count <= miss_inc_s;
                        if (miss_hit_s) begin
                            lost    <= 1'b1;
                            state_r <= LOST;
                        end
                    end else begin
                        interval_r <= interval_r + ONE_C;
                    end
                end
                LOST: begin
                    // No timeouts here; a tick restarts tracking, lost stays set
                    if (tick_in) begin
                        interval_r <= ONE_C;
                        state_r    <= TRACK;
                    end else begin
                        interval_r <= interval_r + ONE_C;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    interval_r <= ZERO_C;
                end
            endcase
            // clear overrides any miss processed in the same cycle
            if (clear) begin
                lost       <= 1'b0;
                miss_count <= 8'd0;
`ifdef TICK_WD_STATS_EN
                good_count <= 16'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_tick_watchdog.sv
// -----------------------------------------------------------------------------
// tb_tick_watchdog
//   Directed, scoreboard-based bench for tick_watchdog with EXPECTED=20,
//   TOLERANCE=2 (window 18..22), MISS_LIMIT=3, CNT_W=8. Expected values are
//   queued as stimulus is applied and popped/compared after the DUT updates.
// -----------------------------------------------------------------------------
module tb_tick_watchdog;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       tick_in;
    logic       clear;
    logic       locked;
    logic       early_err;
    logic       late_err;
    logic       lost;
    logic [7:0] miss_count;
    logic [7:0] last_period;
`ifdef TICK_WD_STATS_EN
    logic [15:0] good_count;
`endif

    tick_watchdog #(
        .EXPECTED   (20),
        .TOLERANCE  (2),
        .MISS_LIMIT (3),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tick_in     (tick_in),
        .clear       (clear),
        .locked      (locked),
        .early_err   (early_err),
        .late_err    (late_err),
        .lost        (lost),
        .miss_count  (miss_count),
        .last_period (last_period)
`ifdef TICK_WD_STATS_EN
        ,
        .good_count  (good_count)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   late_seen;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return {31'd0, locked};
            1: return {31'd0, early_err};
            2: return {31'd0, late_err};
            3: return {31'd0, lost};
            4: return {24'd0, miss_count};
            5: return {24'd0, last_period};
`ifdef TICK_WD_STATS_EN
            6: return {16'd0, good_count};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_outs(input string step, input int lk, input int ee, input int le,
                             input int ls, input int mc, input int lp);
        push($sformatf("%s.locked", step),      0, 32'(lk));
        push($sformatf("%s.early_err", step),   1, 32'(ee));
        push($sformatf("%s.late_err", step),    2, 32'(le));
        push($sformatf("%s.lost", step),        3, 32'(ls));
        push($sformatf("%s.miss_count", step),  4, 32'(mc));
        push($sformatf("%s.last_period", step), 5, 32'(lp));
    endtask

    task automatic check_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, observe(e.sel), e.val);
        end
    endtask

    // Advance one clock edge and settle just after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Tick sampled at the next edge; outputs reflect it on return
    task automatic pulse_tick();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
    endtask

    // Tick exactly p cycles after the previous tick
    task automatic tick_after(input int p);
        repeat (p - 1) cyc();
        pulse_tick();
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        tick_in = 1'b0;
        clear   = 1'b0;

        // Reset state
        #12;
        push_outs("reset", 0, 0, 0, 0, 0, 0);
`ifdef TICK_WD_STATS_EN
        push("reset.good_count", 6, 32'd0);
`endif
        check_all();
        cyc();
        reset  = 1'b0;
        enable = 1'b1;
        cyc();

        // 1: first tick arms, second locks
        pulse_tick();
        push_outs("t1.arm", 0, 0, 0, 0, 0, 0);
        check_all();
        tick_after(20);
        push_outs("t1.lock", 1, 0, 0, 0, 0, 20);
        check_all();
        tick_after(20);
        tick_after(20);
        push_outs("t1.steady", 1, 0, 0, 0, 0, 20);
        check_all();

        // 2: early tick, single-cycle pulse, then recovery
        tick_after(17);
        push_outs("t2.early", 0, 1, 0, 0, 1, 20);
        check_all();
        cyc();
        push("t2.early_one_cycle", 1, 32'd0);
        check_all();
        tick_after(19);
        push_outs("t2.recover", 1, 0, 0, 0, 0, 20);
        check_all();

        // 3: window edges are good, then timeouts into LOST
        tick_after(18);
        push_outs("t3.lo_edge", 1, 0, 0, 0, 0, 18);
        check_all();
        tick_after(22);
        push_outs("t3.hi_edge", 1, 0, 0, 0, 0, 22);
        check_all();
        repeat (21) cyc();
        push("t3.no_late_yet", 2, 32'd0);
        check_all();
        cyc();
        push_outs("t3.late1", 0, 0, 1, 0, 1, 22);
        check_all();
        cyc();
        push("t3.late1_one_cycle", 2, 32'd0);
        check_all();
        repeat (20) cyc();
        push("t3.late2_pending", 2, 32'd0);
        check_all();
        cyc();
        push_outs("t3.late2", 0, 0, 1, 0, 2, 22);
        check_all();
        repeat (21) cyc();
        push("t3.late3_pending", 3, 32'd0);
        check_all();
        cyc();
        push_outs("t3.late3", 0, 0, 1, 1, 3, 22);
        check_all();
        late_seen = 0;
        repeat (80) begin
            cyc();
            if (late_err) late_seen++;
        end
        cmp("t3.no_late_in_lost", 32'(late_seen), 32'd0);
        push_outs("t3.lost_sticky", 0, 0, 0, 1, 3, 22);
        check_all();

        // 4: clear from LOST, then re-lock
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        push("t4.clear.lost", 3, 32'd0);
        push("t4.clear.miss", 4, 32'd0);
        check_all();
        pulse_tick();
        push_outs("t4.rearm", 0, 0, 0, 0, 0, 22);
        check_all();
        tick_after(20);
        push_outs("t4.relock", 1, 0, 0, 0, 0, 20);
        check_all();

        // clear coinciding with an early miss: clear wins for miss_count
        repeat (16) cyc();
        tick_in = 1'b1;
        clear   = 1'b1;
        cyc();
        tick_in = 1'b0;
        clear   = 1'b0;
        push_outs("t4.clear_vs_miss", 0, 1, 0, 0, 0, 20);
        check_all();
        tick_after(20);
        push_outs("t4.after_clear_miss", 1, 0, 0, 0, 0, 20);
        check_all();

        // 5: asynchronous reset mid-interval
        repeat (5) cyc();
        #2;
        reset = 1'b1;
        #1;
        push_outs("t5.async_reset", 0, 0, 0, 0, 0, 0);
        check_all();
        #2;
        reset = 1'b0;
        cyc();
        pulse_tick();
        push_outs("t5.arm_only", 0, 0, 0, 0, 0, 0);
        check_all();
        tick_after(20);
        push_outs("t5.lock", 1, 0, 0, 0, 0, 20);
        check_all();

        // 6: enable=0 clears everything next cycle; re-enable re-arms
        repeat (7) cyc();
        enable = 1'b0;
        cyc();
        push_outs("t6.disabled", 0, 0, 0, 0, 0, 0);
`ifdef TICK_WD_STATS_EN
        push("t6.disabled.good_count", 6, 32'd0);
`endif
        check_all();
        repeat (3) cyc();
        enable = 1'b1;
        cyc();
        pulse_tick();
        push_outs("t6.arm_only", 0, 0, 0, 0, 0, 0);
        check_all();
        for (int i = 0; i < 4; i++) tick_after(20);
        push_outs("t6.four_good", 1, 0, 0, 0, 0, 20);
`ifdef TICK_WD_STATS_EN
        push("t6.good_count4", 6, 32'd4);
`endif
        check_all();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        push("t6.clear.locked_kept", 0, 32'd1);
`ifdef TICK_WD_STATS_EN
        push("t6.clear.good_count", 6, 32'd0);
`endif
        check_all();

        // miss_count saturation: continuous ticks alternate TRACK early-miss / LOST
        tick_in = 1'b1;
        repeat (600) cyc();
        tick_in = 1'b0;
        push("sat.miss_count", 4, 32'd255);
        push("sat.lost", 3, 32'd1);
        push("sat.locked", 0, 32'd0);
        check_all();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        push("sat.clear.miss", 4, 32'd0);
        push("sat.clear.lost", 3, 32'd0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
